// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: round-robin writeback arbiter for the single VRF write port,
// with a one-cycle registered output stage and a per-register busy scoreboard
// that offers two read-address hazard checks to issue logic.
// Build option: define VRF_WB_ZERO_DROP_EN to suppress rf_we for writes to v0
// (the handshake and pointer advance still happen; the scoreboard is unchanged).
module vrf_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  input  logic                        sb_set_valid,
  input  logic [ADDR_W-1:0]           sb_set_addr,
  output logic                        sb_set_ready,
  input  logic [ADDR_W-1:0]           chk_addr_a,
  input  logic [ADDR_W-1:0]           chk_addr_b,
  output logic                        chk_hazard_a,
  output logic                        chk_hazard_b,
  output logic [(1<<ADDR_W)-1:0]      busy_vec
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREGS = 1 << ADDR_W;

  // Round-robin pointer: the requester searched first this cycle.
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  // Registered write stage feeding the VRF port.
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Busy scoreboard, bit r set while a write to register r is outstanding.
  logic [NREGS-1:0]  busy_q, busy_d;

  // Arbitration results.
  logic              win_found;
  int unsigned       win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_keep;
  logic              sb_set_fire;

  // Search upward from the pointer (mod NUM_REQ); first asserted valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[(32'(ptr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = (32'(ptr_q) + k) % NUM_REQ;
      end
    end
  end

  // One-hot grant and selection of the winning address/data.
  always_comb begin
    req_ready = '0;
    win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    win_data  = req_data[win_idx*DATA_W +: DATA_W];
    if (win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Decide whether a granted transfer actually drives the VRF port.
  always_comb begin
`ifdef VRF_WB_ZERO_DROP_EN
    win_keep = win_found && (win_addr != '0);
`else
    win_keep = win_found;
`endif
  end

  // Next pointer and next output-stage contents.
  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = win_keep;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (win_found) begin
      ptr_d = PTR_W'((win_idx + 1) % NUM_REQ);
    end
    if (win_keep) begin
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
    end
  end

  // Scoreboard update: the committing write clears, then a reservation sets,
  // so a same-register set in the commit cycle leaves the register busy.
  always_comb begin
    sb_set_ready = !busy_q[sb_set_addr];
    sb_set_fire  = sb_set_valid && sb_set_ready && (sb_set_addr != '0);
    busy_d       = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (sb_set_fire) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Hazard checks read only registered scoreboard state (no bypass).
  always_comb begin
    chk_hazard_a = busy_q[chk_addr_a];
    chk_hazard_b = busy_q[chk_addr_b];
    busy_vec     = busy_q;
    rf_we        = rf_we_q;
    rf_waddr     = rf_waddr_q;
    rf_wdata     = rf_wdata_q;
  end

  // State registers; reset discards any write sitting in the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb_vrf_wb_arbiter: directed self-checking bench for vrf_wb_arbiter
// (NUM_REQ=3, DATA_W=128, ADDR_W=5). Honours VRF_WB_ZERO_DROP_EN if defined.
module tb_vrf_wb_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned ADDR_W  = 5;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      sb_set_valid;
  logic [ADDR_W-1:0]         sb_set_addr;
  logic                      sb_set_ready;
  logic [ADDR_W-1:0]         chk_addr_a;
  logic [ADDR_W-1:0]         chk_addr_b;
  logic                      chk_hazard_a;
  logic                      chk_hazard_b;
  logic [(1<<ADDR_W)-1:0]    busy_vec;

  int n_cmp;
  int n_err;

  vrf_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr), .sb_set_ready(sb_set_ready),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .chk_hazard_a(chk_hazard_a), .chk_hazard_b(chk_hazard_b),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Expected round-robin grant order and addresses with all three requesting.
  int unsigned       rr_grant [4] = '{0, 1, 2, 0};
  logic [ADDR_W-1:0] rr_addr  [4] = '{5'd1, 5'd2, 5'd3, 5'd1};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    sb_set_valid = 1'b0; sb_set_addr = '0; chk_addr_a = '0; chk_addr_b = '0;

    // 1. async reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_rf_we", 128'(rf_we), 128'd0);
    check("rst_busy", 128'(busy_vec), 128'd0);
    check("rst_waddr", 128'(rf_waddr), 128'd0);
    check("rst_ready", 128'(req_ready), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 2. all three requesting: grants 0,1,2,0, each write one cycle later
    set_req(0, 5'd1, 128'hA0);
    set_req(1, 5'd2, 128'hA1);
    set_req(2, 5'd3, 128'hA2);
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #0;
      check("rr_grant", 128'(req_ready), 128'(3'b001 << rr_grant[i]));
      tick();
      check("rr_we", 128'(rf_we), 128'd1);
      check("rr_waddr", 128'(rf_waddr), 128'(rr_addr[i]));
      check("rr_wdata", rf_wdata, 128'hA0 + 128'(rr_grant[i]));
    end
    req_valid = '0;
    tick();
    check("rr_idle_we", 128'(rf_we), 128'd0);
    check("rr_hold_waddr", 128'(rf_waddr), 128'd1);

    // 3. requester 2 alone for 4 cycles (pointer at 1): back-to-back grants
    set_req(2, 5'd9, 128'hB2);
    req_valid = 3'b100;
    #0;
    check("solo_grant", 128'(req_ready), 128'(3'b100));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("solo_we", 128'(rf_we), 128'd1);
      check("solo_waddr", 128'(rf_waddr), 128'd9);
    end
    req_valid = '0;
    tick();
    check("solo_idle_we", 128'(rf_we), 128'd0);

    // 4. reserve v5, retry while busy, then write it back
    sb_set_valid = 1'b1; sb_set_addr = 5'd5; chk_addr_a = 5'd5; chk_addr_b = 5'd0;
    #0;
    check("sb_ready_free", 128'(sb_set_ready), 128'd1);
    tick();
    check("sb_busy5", 128'(busy_vec), 128'(32'h20));
    check("sb_haz_a", 128'(chk_hazard_a), 128'd1);
    check("sb_haz_b0", 128'(chk_hazard_b), 128'd0);
    check("sb_ready_busy", 128'(sb_set_ready), 128'd0);
    tick();
    check("sb_retry_nochg", 128'(busy_vec), 128'(32'h20));
    sb_set_valid = 1'b0;
    set_req(1, 5'd5, 128'hC1);
    req_valid = 3'b010;
    #0;
    check("wr5_grant", 128'(req_ready), 128'(3'b010));
    tick();
    req_valid = '0;
    check("wr5_we", 128'(rf_we), 128'd1);
    check("wr5_waddr", 128'(rf_waddr), 128'd5);
    check("wr5_haz_nobypass", 128'(chk_hazard_a), 128'd1);
    tick();
    check("wr5_haz_clear", 128'(chk_hazard_a), 128'd0);
    check("wr5_busy_clear", 128'(busy_vec), 128'd0);

    // 5. write to free v7 commits in the same cycle v7 is reserved: set wins;
    //    a reservation of v8 in the same cycle also applies
    set_req(0, 5'd7, 128'hD0);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    check("sw_we", 128'(rf_we), 128'd1);
    check("sw_waddr", 128'(rf_waddr), 128'd7);
    sb_set_valid = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set_valid = 1'b0;
    check("sw_set_wins", 128'(busy_vec), 128'(32'h80));
    // clear v7 with a write while reserving v8: both take effect
    set_req(1, 5'd7, 128'hD1);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    sb_set_valid = 1'b1; sb_set_addr = 5'd8;
    tick();
    sb_set_valid = 1'b0;
    check("sw_diff_regs", 128'(busy_vec), 128'(32'h100));

    // 6. write to v0 from requester 0
    set_req(0, 5'd0, 128'hE0);
    req_valid = 3'b001;
    #0;
    check("z_grant", 128'(req_ready), 128'(3'b001));
    tick();
    req_valid = '0;
`ifdef VRF_WB_ZERO_DROP_EN
    check("z_we_drop", 128'(rf_we), 128'd0);
`else
    check("z_we", 128'(rf_we), 128'd1);
    check("z_waddr", 128'(rf_waddr), 128'd0);
`endif
    sb_set_valid = 1'b1; sb_set_addr = 5'd0; chk_addr_a = 5'd0;
    #0;
    check("z_set_ready", 128'(sb_set_ready), 128'd1);
    tick();
    sb_set_valid = 1'b0;
    check("z_busy0", 128'(busy_vec[0]), 128'd0);
    check("z_haz0", 128'(chk_hazard_a), 128'd0);

    // 7. reset mid-cycle with a granted transfer pending: write never appears
    sb_set_valid = 1'b1; sb_set_addr = 5'd3;
    tick();
    sb_set_valid = 1'b0;
    set_req(1, 5'd12, 128'hF1);
    req_valid = 3'b010;
    #0;
    check("rst7_grant", 128'(req_ready), 128'(3'b010));
    #2 rst = 1'b1;
    #1;
    check("rst7_busy_async", 128'(busy_vec), 128'd0);
    check("rst7_we_async", 128'(rf_we), 128'd0);
    tick();
    check("rst7_we_held", 128'(rf_we), 128'd0);
    req_valid = '0;
    rst = 1'b0;
    tick();
    check("rst7_we_after", 128'(rf_we), 128'd0);
    check("rst7_waddr", 128'(rf_waddr), 128'd0);
    // pointer back at 0: requester 0 wins over 1 and 2
    set_req(0, 5'd4, 128'h40);
    req_valid = 3'b111;
    #0;
    check("rst7_ptr0", 128'(req_ready), 128'(3'b001));
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
